register_bank_scoreboard: RTL

- Parametrised successor to the CPU's 16x32 register bank.
- Configurable width, register count and read-port count; register 0 is hardwired to zero.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard: the issue stage marks a destination register pending; writeback clears the mark. Decode stalls on hazards using the busy outputs.

---
 rtl/riskow_regfile_pkg.sv | 17 +
 rtl/regfile_read_port.sv | 65 ++++++
 rtl/register_bank_scoreboard.sv | 97 +++++++++
 3 files changed

// File: rtl/riskow_regfile_pkg.sv
// Shared constants and helpers for the parametrised register bank.
// Contents:
//   DEFAULT_DATA_WIDTH / DEFAULT_NUM_REGS - default geometry of the bank
//   ZERO_REG                              - index of the hardwired-zero register
//   sliceOffset()                         - bit offset of a port's slice in a packed bus
package riskow_regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_REGS   = 16;
  localparam int ZERO_REG           = 0;

  // Offset of slice 'port' in a bus made of equal 'width'-bit slices.
  function automatic int sliceOffset(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register bank.
// Selects the addressed register and its busy bit. Register 0 is forced to
// read zero and never busy. When BYPASS is set, a write landing on the
// addressed register in the current cycle is forwarded to the port.
// Ports:
//   regNum      in  read index
//   regs        in  stored register contents
//   busy        in  stored busy bits
//   writeEnable in  write in progress this cycle
//   wRegNum     in  index being written
//   wDataIn     in  data being written
//   markEnable  in  mark in progress this cycle
//   markRegNum  in  index being marked
//   dataOut     out read data
//   busyOut     out busy flag of the addressed register
module regfile_read_port
  import riskow_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int BYPASS     = 1,
  parameter int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0]                   regNum,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
  input  logic [NUM_REGS-1:0]                 busy,
  input  logic                                writeEnable,
  input  logic [ADDR_W-1:0]                   wRegNum,
  input  logic [DATA_WIDTH-1:0]               wDataIn,
  input  logic                                markEnable,
  input  logic [ADDR_W-1:0]                   markRegNum,
  output logic [DATA_WIDTH-1:0]               dataOut,
  output logic                                busyOut
);

  logic isZeroS;
  logic writeHitS;
  logic markHitS;

  // Read mux with zero-register masking and optional write forwarding.
  always_comb begin
    isZeroS   = (regNum == ADDR_W'(ZERO_REG));
    writeHitS = (BYPASS != 0) && writeEnable && (wRegNum == regNum) && !isZeroS;
    markHitS  = markEnable && (markRegNum == regNum);
    dataOut   = regs[regNum];
    busyOut   = busy[regNum];
    if (isZeroS) begin
      dataOut = {DATA_WIDTH{1'b0}};
      busyOut = 1'b0;
    end else if (writeHitS) begin
      dataOut = wDataIn;
      // A same-cycle mark means a new producer takes ownership, so the
      // writeback does not release the register.
      if (markHitS) begin
        busyOut = busy[regNum];
      end else begin
        busyOut = 1'b0;
      end
    end else begin
      dataOut = regs[regNum];
      busyOut = busy[regNum];
    end
  end

endmodule

// File: rtl/register_bank_scoreboard.sv
// Parametrised register bank with a per-register busy scoreboard.
// Issue marks a destination pending (markEnable); writeback stores the data
// and clears the mark (writeEnable). Register 0 is hardwired to zero.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   regNums      read indices, port p at [p*ADDR_W +: ADDR_W]
//   dataOut      read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   busyOut      per-port pending-write flag
//   wRegNum, wDataIn, writeEnable   writeback port
//   markRegNum, markEnable          scoreboard mark port
//   anyBusy      registered OR of all busy bits
module register_bank_scoreboard
  import riskow_regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS       = DEFAULT_NUM_REGS,
  parameter int NUM_READ_PORTS = 2,
  parameter int BYPASS         = 1,
  localparam int ADDR_W        = $clog2(NUM_REGS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_READ_PORTS*ADDR_W-1:0]     regNums,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] dataOut,
  output logic [NUM_READ_PORTS-1:0]            busyOut,
  input  logic [ADDR_W-1:0]                    wRegNum,
  input  logic [DATA_WIDTH-1:0]                wDataIn,
  input  logic                                 writeEnable,
  input  logic [ADDR_W-1:0]                    markRegNum,
  input  logic                                 markEnable,
  output logic                                 anyBusy
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regsR;
  logic [NUM_REGS-1:0]                 busyR;
  logic [NUM_REGS-1:0]                 busyNextS;
  logic                                anyBusyR;
  logic                                writeHitS;
  logic                                markHitS;

  assign writeHitS = writeEnable && (wRegNum != ADDR_W'(ZERO_REG));
  assign markHitS  = markEnable && (markRegNum != ADDR_W'(ZERO_REG));
  assign anyBusy   = anyBusyR;

  // Next-state busy vector: writeback clears, mark sets; mark applied last
  // so that a same-index mark wins over the clearing writeback.
  always_comb begin
    busyNextS = busyR;
    if (writeHitS) begin
      busyNextS[wRegNum] = 1'b0;
    end else begin
      busyNextS = busyR;
    end
    if (markHitS) begin
      busyNextS[markRegNum] = 1'b1;
    end else begin
      busyNextS[ZERO_REG] = busyNextS[ZERO_REG];
    end
    busyNextS[ZERO_REG] = 1'b0;
  end

  // Register storage, busy bits and the registered any-busy summary.
  always_ff @(posedge clk) begin
    if (reset) begin
      regsR    <= '0;
      busyR    <= {NUM_REGS{1'b0}};
      anyBusyR <= 1'b0;
    end else begin
      if (writeHitS) begin
        regsR[wRegNum] <= wDataIn;
      end
      busyR    <= busyNextS;
      anyBusyR <= |busyNextS;
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : gReadPort
    regfile_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_REGS  (NUM_REGS),
      .BYPASS    (BYPASS),
      .ADDR_W    (ADDR_W)
    ) uReadPort (
      .regNum     (regNums[sliceOffset(p, ADDR_W) +: ADDR_W]),
      .regs       (regsR),
      .busy       (busyR),
      .writeEnable(writeEnable),
      .wRegNum    (wRegNum),
      .wDataIn    (wDataIn),
      .markEnable (markEnable),
      .markRegNum (markRegNum),
      .dataOut    (dataOut[sliceOffset(p, DATA_WIDTH) +: DATA_WIDTH]),
      .busyOut    (busyOut[p])
    );
  end

endmodule
